// File: rtl/julia_dispatcher.sv
// julia_dispatcher: frame-scan master for a single julia worker.
// Walks the pixel grid in raster order, starts the worker on each (x, y) with
// the frame's Julia constant, writes the returned color to the worker-supplied
// address, then releases the worker with MC_done.
// Optional build macro: JULIA_DISPATCHER_PERF_EN adds the frame_cycles counter.
//
// Handshakes:
//   worker : JW_start is a one-cycle pulse, only ever raised while JW_ready=1.
//            JW_done is held by the worker until the one-cycle MC_done pulse.
//   memory : wr_req/wr_addr/wr_data stay stable while wr_waitrequest=1; the
//            write is accepted on the cycle with wr_req=1 and wr_waitrequest=0.
module julia_dispatcher #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COORD_W = 10,
    parameter int WIDTH   = 22
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic [WIDTH-1:0]   c_real_in,
    input  logic [WIDTH-1:0]   c_imag_in,
    output logic               busy,
    output logic               frame_done,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [WIDTH-1:0]   c_real_out,
    output logic [WIDTH-1:0]   c_imag_out,
    output logic               JW_start,
    input  logic               JW_ready,
    input  logic               JW_done,
    input  logic [31:0]        color,
    input  logic [31:0]        address,
    output logic               MC_done,
    output logic               wr_req,
    output logic [31:0]        wr_addr,
    output logic [31:0]        wr_data,
    input  logic               wr_waitrequest,
`ifdef JULIA_DISPATCHER_PERF_EN
    output logic [31:0]        frame_cycles,
`endif
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        WRITE     = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic last_x;
    logic last_y;

    assign last_x    = (x == COORD_W'(H_RES - 1));
    assign last_y    = (y == COORD_W'(V_RES - 1));
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the single-cycle strobes (JW_start, MC_done, frame_done).
    always_comb begin
        state_nxt  = state;
        JW_start   = 1'b0;
        MC_done    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (JW_ready) begin
                    JW_start  = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (JW_done) state_nxt = WRITE;
            end
            WRITE: begin
                if (!wr_waitrequest) state_nxt = RELEASE;
            end
            RELEASE: begin
                MC_done    = 1'b1;
                frame_done = last_x && last_y;
                state_nxt  = (last_x && last_y) ? IDLE : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame context, pixel cursor and memory write port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            x          <= '0;
            y          <= '0;
            c_real_out <= '0;
            c_imag_out <= '0;
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        busy       <= 1'b1;
                        x          <= '0;
                        y          <= '0;
                        c_real_out <= c_real_in;
                        c_imag_out <= c_imag_in;
                    end
                end
                WAIT_DONE: begin
                    if (JW_done) begin
                        wr_addr <= address;
                        wr_data <= color;
                        wr_req  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (!wr_waitrequest) wr_req <= 1'b0;
                end
                RELEASE: begin
                    // Cursor only moves after the pixel is released, so x/y stay
                    // stable for the worker from ISSUE through RELEASE.
                    if (last_x) begin
                        x <= '0;
                        if (last_y) begin
                            y    <= '0;
                            busy <= 1'b0;
                        end else begin
                            y <= y + COORD_W'(1);
                        end
                    end else begin
                        x <= x + COORD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef JULIA_DISPATCHER_PERF_EN
    // Busy-cycle counter: cleared on frame accept, counts every busy cycle
    // (including the frame_done cycle), saturates, then holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cycles <= '0;
        end else if (state == IDLE && frame_start) begin
            frame_cycles <= '0;
        end else if (busy && frame_cycles != 32'hFFFF_FFFF) begin
            frame_cycles <= frame_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_julia_dispatcher.sv
// Testbench for julia_dispatcher on a 4x2 grid. A behavioural worker and memory
// model drive the handshakes; an expected-write queue and a raster pixel index
// predict every start, write and release. Frame lengths come from a vector table
// plus randomized configurations.
module tb_julia_dispatcher;

    localparam int H_RES   = 4;
    localparam int V_RES   = 2;
    localparam int COORD_W = 10;
    localparam int WIDTH   = 22;
    localparam int NPIX    = H_RES * V_RES;

    logic               clk = 1'b0;
    logic               rst;
    logic               frame_start;
    logic [WIDTH-1:0]   c_real_in;
    logic [WIDTH-1:0]   c_imag_in;
    logic               busy;
    logic               frame_done;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [WIDTH-1:0]   c_real_out;
    logic [WIDTH-1:0]   c_imag_out;
    logic               JW_start;
    logic               JW_ready;
    logic               JW_done;
    logic [31:0]        color;
    logic [31:0]        address;
    logic               MC_done;
    logic               wr_req;
    logic [31:0]        wr_addr;
    logic [31:0]        wr_data;
    logic               wr_waitrequest;
    logic [2:0]         state_dbg;
`ifdef JULIA_DISPATCHER_PERF_EN
    logic [31:0]        frame_cycles;
`endif

    julia_dispatcher #(
        .H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W), .WIDTH(WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .c_real_in(c_real_in), .c_imag_in(c_imag_in),
        .busy(busy), .frame_done(frame_done), .x(x), .y(y),
        .c_real_out(c_real_out), .c_imag_out(c_imag_out),
        .JW_start(JW_start), .JW_ready(JW_ready), .JW_done(JW_done),
        .color(color), .address(address), .MC_done(MC_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_waitrequest(wr_waitrequest),
`ifdef JULIA_DISPATCHER_PERF_EN
        .frame_cycles(frame_cycles),
`endif
        .state_dbg(state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        int               lat;
        int               stall;
        int               rdy;
        logic [WIDTH-1:0] cr;
        logic [WIDTH-1:0] ci;
        int               exp_cycles;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Model state.
    int               cfg_lat, cfg_stall, cfg_rdy;
    int               pix_idx, w_cnt, idle_cnt, stall_left, hold_cnt;
    int               busy_cycles, fd_cnt, wr_cnt;
    bit               w_busy, w_done, write_ok, prev_busy;
    logic [31:0]      held_addr, held_data;
    logic [WIDTH-1:0] exp_cr, exp_ci;
    logic [63:0]      exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        w_busy = 0; w_done = 0; write_ok = 0; prev_busy = 0;
        pix_idx = 0; w_cnt = 0; idle_cnt = 0; hold_cnt = 0;
        stall_left = cfg_stall;
        exp_q.delete();
        JW_ready = 1'b0; JW_done = 1'b0; wr_waitrequest = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_ctl"}, {59'd0, busy, frame_done, JW_start, MC_done, wr_req}, 64'd0);
        chk({tag, "_xy"}, {44'd0, x, y}, 64'd0);
        chk({tag, "_c"}, {20'd0, c_real_out, c_imag_out}, 64'd0);
        chk({tag, "_wr"}, {wr_addr, wr_data}, 64'd0);
        chk({tag, "_state"}, 64'(state_dbg), 64'd0);
    endtask

    // Driver + monitor for one clock: drive inputs at the falling edge from the
    // worker/memory model, then 1ns later check what the DUT presents this cycle.
    task automatic cycle(input logic fs, input logic [WIDTH-1:0] cr, input logic [WIDTH-1:0] ci);
        logic [63:0] e;
        @(negedge clk);
        frame_start = fs;
        c_real_in   = cr;
        c_imag_in   = ci;
        if (busy && !prev_busy) idle_cnt = 0;
        prev_busy = busy;
        if (w_busy) begin
            JW_ready = 1'b0;
            if (!w_done) begin
                w_cnt--;
                color   = $urandom;
                address = $urandom;
                if (w_cnt <= 0) begin
                    w_done = 1;
                    exp_q.push_back({address, color});
                end
            end
        end else begin
            JW_ready = (idle_cnt >= cfg_rdy);
            idle_cnt++;
            color   = $urandom;
            address = $urandom;
        end
        JW_done = w_done;
        if (wr_req) begin
            if (stall_left > 0) begin
                wr_waitrequest = 1'b1;
                stall_left--;
            end else begin
                wr_waitrequest = 1'b0;
            end
        end else begin
            wr_waitrequest = 1'($urandom_range(0, 1));
        end
        #1;
        if (busy) busy_cycles++;
        if (JW_start) begin
            chk("start_ready", 64'(JW_ready), 64'd1);
            chk("start_worker_idle", 64'(w_busy), 64'd0);
            chk("start_x", 64'(x), 64'(pix_idx % H_RES));
            chk("start_y", 64'(y), 64'(pix_idx / H_RES));
            chk("start_c_real", 64'(c_real_out), 64'(exp_cr));
            chk("start_c_imag", 64'(c_imag_out), 64'(exp_ci));
            w_busy = 1;
            w_cnt  = cfg_lat;
        end
        if (wr_req) begin
            if (hold_cnt == 0) begin
                held_addr = wr_addr;
                held_data = wr_data;
            end else begin
                chk("wr_addr_stable", 64'(wr_addr), 64'(held_addr));
                chk("wr_data_stable", 64'(wr_data), 64'(held_data));
            end
            hold_cnt++;
            if (!wr_waitrequest) begin
                chk("exp_q_size", 64'(exp_q.size()), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e[63:32]));
                    chk("wr_data", 64'(wr_data), 64'(e[31:0]));
                end
                chk("wr_hold_cycles", 64'(hold_cnt), 64'(cfg_stall + 1));
                hold_cnt   = 0;
                stall_left = cfg_stall;
                write_ok   = 1;
                wr_cnt++;
            end
        end
        if (MC_done) begin
            chk("mc_after_write", 64'(write_ok), 64'd1);
            chk("mc_x", 64'(x), 64'(pix_idx % H_RES));
            chk("mc_y", 64'(y), 64'(pix_idx / H_RES));
            chk("frame_done_at_last", 64'(frame_done), 64'(pix_idx == NPIX - 1));
            w_busy   = 0;
            w_done   = 0;
            write_ok = 0;
            idle_cnt = 0;
            pix_idx++;
        end else if (frame_done) begin
            chk("frame_done_with_mc", 64'(MC_done), 64'd1);
        end
        if (frame_done) begin
            fd_cnt++;
            chk("done_c_real", 64'(c_real_out), 64'(exp_cr));
        end
    endtask

    task automatic run_frame(input vec_t v);
        cfg_lat = v.lat; cfg_stall = v.stall; cfg_rdy = v.rdy;
        stall_left = v.stall;
        pix_idx = 0; busy_cycles = 0; fd_cnt = 0; wr_cnt = 0;
        exp_cr = v.cr; exp_ci = v.ci;
        cycle(1'b1, v.cr, v.ci);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 9) cycle(1'b1, 22'h3FFC00, 22'($urandom));
            else          cycle(1'b0, 22'($urandom), 22'($urandom));
`ifdef JULIA_DISPATCHER_PERF_EN
            if (cyc == 0) chk("perf_clear", 64'(frame_cycles), 64'd0);
`endif
            if (fd_cnt > 0) break;
        end
        chk("frame_done_count", 64'(fd_cnt), 64'd1);
        cycle(1'b0, 22'($urandom), 22'($urandom));
        chk("busy_drop", 64'(busy), 64'd0);
        chk("writes_per_frame", 64'(wr_cnt), 64'(NPIX));
        chk("frame_len", 64'(busy_cycles), 64'(v.exp_cycles));
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef JULIA_DISPATCHER_PERF_EN
        chk("perf_count", 64'(frame_cycles), 64'(v.exp_cycles));
`endif
        cycle(1'b0, 22'($urandom), 22'($urandom));
        cycle(1'b0, 22'($urandom), 22'($urandom));
        chk("idle_no_queue", 64'(busy), 64'd0);
`ifdef JULIA_DISPATCHER_PERF_EN
        chk("perf_hold", 64'(frame_cycles), 64'(v.exp_cycles));
`endif
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        // Reset block.
        rst = 1'b1;
        c_real_in = '0; c_imag_in = '0; color = '0; address = '0;
        cfg_lat = 1; cfg_stall = 0; cfg_rdy = 0;
        reset_model();
        repeat (3) @(negedge clk);
        #1;
        rst_chk("por");
        rst = 1'b0;

        // Vector table: worker latency, write stall, ready delay, c, frame length.
        tbl[0] = '{lat: 3, stall: 0, rdy: 0,  cr: 22'h000400, ci: 22'h000123, exp_cycles: 48};
        tbl[1] = '{lat: 4, stall: 0, rdy: 0,  cr: 22'h000400, ci: 22'h3FF800, exp_cycles: 56};
        tbl[2] = '{lat: 1, stall: 0, rdy: 0,  cr: 22'h155555, ci: 22'h2AAAAA, exp_cycles: 32};
        tbl[3] = '{lat: 2, stall: 5, rdy: 0,  cr: 22'h3FFFFF, ci: 22'h000001, exp_cycles: 80};
        tbl[4] = '{lat: 1, stall: 0, rdy: 10, cr: 22'h200000, ci: 22'h1FFFFF, exp_cycles: 112};
        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        // Randomized frames; length follows from per-pixel phase durations.
        for (int i = 0; i < 3; i++) begin
            rv.lat   = $urandom_range(1, 6);
            rv.stall = $urandom_range(0, 4);
            rv.rdy   = $urandom_range(0, 3);
            rv.cr    = 22'($urandom);
            rv.ci    = 22'($urandom);
            rv.exp_cycles = NPIX * (rv.rdy + 1 + rv.lat + rv.stall + 1 + 1);
            run_frame(rv);
        end

        // Asynchronous reset while a write is stalled.
        cfg_lat = 2; cfg_stall = 1000; cfg_rdy = 0;
        stall_left = cfg_stall; pix_idx = 0;
        exp_cr = 22'h000400; exp_ci = 22'h000000;
        cycle(1'b1, 22'h000400, 22'h000000);
        for (int i = 0; i < 50 && !wr_req; i++) cycle(1'b0, 22'h000400, 22'h000000);
        chk("pre_reset_wr_req", 64'(wr_req), 64'd1);
        cycle(1'b0, 22'h000400, 22'h000000);
        cycle(1'b0, 22'h000400, 22'h000000);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        rst_chk("arst");
        @(negedge clk);
        #1;
        rst_chk("arst_hold");
        rst = 1'b0;
        cfg_stall = 0;
        reset_model();
        run_frame(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
